// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
package audio_pkg;

    // One signed PCM sample as carried on an audiostream.
    typedef logic signed [15:0] audio_sample_t;

    localparam int unsigned SAMPLE_W = 16;

    // 30 MHz system clock divided down to ~44.1 kHz.
    localparam int unsigned CLK_DIV_44K1 = 680;

    // Sink-side request state: idle, strobing, or waiting for the reply.
    typedef enum logic [1:0] {
        ReqIdle,
        ReqStrobe,
        ReqWait
    } req_state_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_sample_sink_if.sv
// audiostream: pull-style sample link. The sink pulses strobe to ask for one
// sample; the source answers some cycles later with write plus the sample.
interface audiostream;
    import audio_pkg::*;

    logic          write;
    audio_sample_t sample;
    logic          strobe;

    modport sink (
        input  write,
        input  sample,
        output strobe
    );

    modport source (
        output write,
        output sample,
        input  strobe
    );

endinterface

// File: rtl/audio_sample_sink_sync_fifo.sv
// Single-clock FIFO with occupancy count. Push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle; pop from empty is ignored.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/audio_sample_sink.sv
// audio_sample_sink: pulls samples from an audiostream source one request at
// a time, buffers them, and releases one sample per divider tick.
module audio_sample_sink
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,           // power of 2, 4..64
    parameter int unsigned CLK_DIV = CLK_DIV_44K1  // >= 8
) (
    input  logic                   clk,
    input  logic                   reset,
    audiostream.sink               src,
    output audio_sample_t          sample_out,
    output logic                   sample_valid,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   underrun,
    output logic                   overrun
);

    localparam int unsigned CNT_W = count_width(DEPTH);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] divider;
    logic             tick;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    audio_sample_t    fifo_head;

    logic             pop_ok;
    logic             push_ok;
    logic [CNT_W-1:0] count_next;
    logic             room;

    req_state_t       req_state;
    logic             strobe_q;

    audio_sample_t    sample_out_q;
    logic             sample_valid_q;
    logic             underrun_q;
    logic             overrun_q;

    assign tick    = (divider == DIV_W'(CLK_DIV - 1));
    assign pop_ok  = tick && !fifo_empty;
    // A full FIFO still takes a write on a tick because the pop frees a slot.
    assign push_ok = src.write && (!fifo_full || pop_ok);

    // Occupancy after this cycle's push/pop; request decisions use this so a
    // write landing in the same cycle is already accounted for.
    always_comb begin
        count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        room       = (count_next <= CNT_W'(DEPTH - 2));
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (src.write),
        .push_data (src.sample),
        .pop       (tick),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Request FSM: at most one outstanding request; any write answers it.
    // Strobe comes only from idle or from a wait that was just answered, so
    // it can never be high on two consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_state <= ReqIdle;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            unique case (req_state)
                ReqIdle: begin
                    if (room) begin
                        req_state <= ReqStrobe;
                        strobe_q  <= 1'b1;
                    end
                end
                ReqStrobe: begin
                    req_state <= src.write ? ReqIdle : ReqWait;
                end
                ReqWait: begin
                    if (src.write) begin
                        if (room) begin
                            req_state <= ReqStrobe;
                            strobe_q  <= 1'b1;
                        end else begin
                            req_state <= ReqIdle;
                        end
                    end
                end
                default: req_state <= ReqIdle;
            endcase
        end
    end

    // Output-rate divider, output register and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            divider        <= tick ? '0 : divider + 1'b1;
            sample_valid_q <= tick;
            underrun_q     <= tick && fifo_empty;
            overrun_q      <= src.write && !push_ok;
            if (pop_ok) begin
                sample_out_q <= fifo_head;
            end
        end
    end

    assign src.strobe   = strobe_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;
    assign fill_level   = fifo_count;

endmodule

// File: tb/tb_audio_sample_sink.sv
// Bench for audio_sample_sink: directed scenarios plus a randomized stream,
// checked against a queue-based model of the sink's rules.
module tb_audio_sample_sink;
    import audio_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CLK_DIV = 680;

    logic          clk = 1'b0;
    logic          reset;
    audio_sample_t sample_out;
    logic          sample_valid;
    logic [4:0]    fill_level;
    logic          underrun;
    logic          overrun;

    audiostream src_if ();

    audio_sample_sink #(
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src          (src_if),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .fill_level   (fill_level),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [15:0] mq[$];
    int          m_div;
    bit          m_pending;
    bit          m_strobe;
    bit          m_valid;
    bit          m_under;
    bit          m_over;
    logic [15:0] m_out;

    task automatic model_reset();
        mq.delete();
        m_div     = 0;
        m_pending = 0;
        m_strobe  = 0;
        m_valid   = 0;
        m_under   = 0;
        m_over    = 0;
        m_out     = 16'h0;
    endtask

    // One clock: drive the source, advance the model across the edge, and
    // return at the following negedge with write deasserted.
    task automatic cycle(input bit w, input logic [15:0] s);
        bit tick;
        bit was_empty;
        bit was_full;
        bit pend_after;
        bit issue;
        src_if.write  = w;
        src_if.sample = s;
        @(posedge clk);
        tick      = (m_div == CLK_DIV - 1);
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        m_valid   = tick;
        m_under   = tick && was_empty;
        if (tick && !was_empty) m_out = mq.pop_front();
        m_over = w && was_full && !tick;
        if (w && !m_over) mq.push_back(s);
        pend_after = w ? 1'b0 : m_pending;
        issue      = !m_strobe && !pend_after && (mq.size() <= DEPTH - 2);
        m_strobe   = issue;
        m_pending  = issue || pend_after;
        m_div      = tick ? 0 : m_div + 1;
        @(negedge clk);
        src_if.write = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        src_if.write = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance until the model shows an output tick; reached=0 if it never does.
    task automatic run_to_tick(output bit reached);
        reached = 0;
        for (int i = 0; i < CLK_DIV + 2; i++) begin
            cycle(1'b0, 16'h0);
            if (m_valid) begin
                reached = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        src_if.write = 1'b0;
        src_if.sample = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({src_if.strobe, sample_valid, underrun, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 0000",
                     {src_if.strobe, sample_valid, underrun, overrun});
        end
        n_checks++;
        if (fill_level !== 5'd0 || sample_out !== 16'sh0) begin
            n_fail++;
            $display("FAIL reset_state: fill %0d out %h expected 0 / 0000", fill_level, sample_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_underrun();
        int first_valid = -1;
        int strobes     = 0;
        do_reset();
        for (int i = 0; i < CLK_DIV + 4; i++) begin
            if (src_if.strobe === 1'b1) strobes++;
            if (sample_valid === 1'b1 && first_valid < 0) begin
                first_valid = i;
                n_checks++;
                if (underrun !== 1'b1 || sample_out !== 16'sh0) begin
                    n_fail++;
                    $display("FAIL idle_tick: underrun %b out %h expected 1 / 0000",
                             underrun, sample_out);
                end
            end
            cycle(1'b0, 16'h0);
        end
        n_checks++;
        if (strobes != 1) begin
            n_fail++;
            $display("FAIL idle_strobes: got %0d expected 1", strobes);
        end
        n_checks++;
        if (first_valid != CLK_DIV) begin
            n_fail++;
            $display("FAIL idle_first_valid_cycle: got %0d expected %0d", first_valid, CLK_DIV);
        end
    endtask

    task automatic test_request_response();
        logic [15:0] vals[$];
        logic [15:0] got[$];
        int          resp_cnt = 0;
        int          max_fill = 0;
        bit          prev_strobe = 0;
        bit          w;
        logic [15:0] d;
        vals = '{16'h1234, 16'h8000, 16'h7FFF};
        for (int i = 0; i < 40; i++) vals.push_back(16'($urandom));
        do_reset();
        for (int i = 0; i < 3 * CLK_DIV + 8; i++) begin
            n_checks++;
            if (src_if.strobe !== m_strobe) begin
                n_fail++;
                $display("FAIL rr_strobe cyc %0d: got %b expected %b", i, src_if.strobe, m_strobe);
            end
            n_checks++;
            if (prev_strobe && src_if.strobe === 1'b1) begin
                n_fail++;
                $display("FAIL rr_strobe_consecutive cyc %0d: got 1 expected 0", i);
            end
            prev_strobe = (src_if.strobe === 1'b1);
            if (sample_valid === 1'b1) got.push_back(sample_out);
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            w = 0;
            d = 16'h0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    w = 1;
                    d = vals.pop_front();
                end
            end
            if (m_strobe) resp_cnt = 3;
            cycle(w, d);
        end
        n_checks++;
        if (max_fill != DEPTH - 1) begin
            n_fail++;
            $display("FAIL rr_max_fill: got %0d expected %0d", max_fill, DEPTH - 1);
        end
        n_checks++;
        if (got.size() < 3) begin
            n_fail++;
            $display("FAIL rr_tick_count: got %0d expected 3", got.size());
        end else if (got[0] !== 16'h1234 || got[1] !== 16'h8000 || got[2] !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL rr_order: got %h %h %h expected 1234 8000 7fff", got[0], got[1], got[2]);
        end
    endtask

    // Leaves the FIFO full for test_full_tick_write.
    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h1000 + 16'(i));
        n_checks++;
        if (fill_level !== 5'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovr_fill_before: got %0d expected %0d", fill_level, DEPTH);
        end
        cycle(1'b1, 16'hDEAD);
        n_checks++;
        if (overrun !== 1'b1 || fill_level !== 5'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovr_pulse: overrun %b fill %0d expected 1 / %0d",
                     overrun, fill_level, DEPTH);
        end
        cycle(1'b0, 16'h0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_one_cycle: got %b expected 0", overrun);
        end
    endtask

    task automatic test_full_tick_write();
        logic [15:0] exp[$];
        logic [15:0] got[$];
        for (int i = 0; i < CLK_DIV + 2 && m_div != CLK_DIV - 1; i++) cycle(1'b0, 16'h0);
        n_checks++;
        if (fill_level !== 5'(DEPTH) || m_div != CLK_DIV - 1) begin
            n_fail++;
            $display("FAIL ftw_pre_tick: fill %0d div %0d expected %0d / %0d",
                     fill_level, m_div, DEPTH, CLK_DIV - 1);
        end
        cycle(1'b1, 16'hBEEF);
        n_checks++;
        if (overrun !== 1'b0 || fill_level !== 5'(DEPTH)) begin
            n_fail++;
            $display("FAIL ftw_no_overrun: overrun %b fill %0d expected 0 / %0d",
                     overrun, fill_level, DEPTH);
        end
        n_checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'sh1000) begin
            n_fail++;
            $display("FAIL ftw_head: valid %b out %h expected 1 / 1000", sample_valid, sample_out);
        end
        for (int i = 1; i < DEPTH; i++) exp.push_back(16'h1000 + 16'(i));
        exp.push_back(16'hBEEF);
        for (int i = 0; i < DEPTH * CLK_DIV + 4; i++) begin
            cycle(1'b0, 16'h0);
            if (sample_valid === 1'b1 && underrun === 1'b0) got.push_back(sample_out);
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL ftw_drain_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                n_checks++;
                if (got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL ftw_drain[%0d]: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_request();
        bit reached;
        do_reset();
        for (int i = 0; i < 8 && !m_strobe; i++) cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({src_if.strobe, sample_valid, underrun, overrun} !== 4'b0000 ||
            fill_level !== 5'd0 || sample_out !== 16'sh0) begin
            n_fail++;
            $display("FAIL rmr_reset_outputs: pulses %b fill %0d out %h expected 0000 / 0 / 0000",
                     {src_if.strobe, sample_valid, underrun, overrun}, fill_level, sample_out);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 16'h00AA);
        n_checks++;
        if (fill_level !== 5'd1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rmr_accept: fill %0d overrun %b expected 1 / 0", fill_level, overrun);
        end
        n_checks++;
        if (src_if.strobe !== m_strobe) begin
            n_fail++;
            $display("FAIL rmr_next_strobe: got %b expected %b", src_if.strobe, m_strobe);
        end
        run_to_tick(reached);
        n_checks++;
        if (!reached || sample_out !== 16'sh00AA || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rmr_output: reached %b out %h underrun %b expected 1 / 00aa / 0",
                     reached, sample_out, underrun);
        end
    endtask

    task automatic test_drain_hold();
        bit reached;
        do_reset();
        cycle(1'b1, 16'h5555);
        run_to_tick(reached);
        n_checks++;
        if (!reached || sample_out !== 16'sh5555 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_first: out %h underrun %b expected 5555 / 0", sample_out, underrun);
        end
        for (int t = 0; t < 3; t++) begin
            run_to_tick(reached);
            n_checks++;
            if (sample_valid !== 1'b1 || underrun !== 1'b1 || sample_out !== 16'sh5555) begin
                n_fail++;
                $display("FAIL drain_hold tick %0d: valid %b underrun %b out %h expected 1 / 1 / 5555",
                         t, sample_valid, underrun, sample_out);
            end
        end
        cycle(1'b1, 16'h0123);
        run_to_tick(reached);
        n_checks++;
        if (sample_out !== 16'sh0123 || underrun !== 1'b0 || sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_recover: out %h underrun %b valid %b expected 0123 / 0 / 1",
                     sample_out, underrun, sample_valid);
        end
    endtask

    task automatic test_random_stream();
        int          resp_cnt = 0;
        bit          w;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 6 * CLK_DIV; i++) begin
            n_checks++;
            if (src_if.strobe !== m_strobe || fill_level !== 5'(mq.size())) begin
                n_fail++;
                $display("FAIL rnd_req cyc %0d: strobe %b fill %0d expected %b / %0d",
                         i, src_if.strobe, fill_level, m_strobe, mq.size());
            end
            n_checks++;
            if ({sample_valid, underrun, overrun} !== {m_valid, m_under, m_over} ||
                sample_out !== m_out) begin
                n_fail++;
                $display("FAIL rnd_out cyc %0d: v/u/o %b out %h expected %b / %h",
                         i, {sample_valid, underrun, overrun}, sample_out,
                         {m_valid, m_under, m_over}, m_out);
            end
            w = 0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) w = 1;
            end
            if (m_strobe) begin
                resp_cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 1500)
                                                       : $urandom_range(1, 8);
            end
            if (!w && $urandom_range(0, 39) == 0) w = 1;
            d = 16'($urandom);
            cycle(w, d);
        end
    endtask

    initial begin
        reset         = 1'b1;
        src_if.write  = 1'b0;
        src_if.sample = '0;
        test_reset();
        test_idle_underrun();
        test_request_response();
        test_overrun();
        test_full_tick_write();
        test_reset_mid_request();
        test_drain_hold();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
